asp_tx_arq_controller: RTL

- Stop-and-wait ARQ sequencer for the ASP output stage.
- Accepts one host word at a time and assigns it a rolling tag.
- Drives the output stage opcode: TXE to transmit, RXA to await the acknowledgement.
- Retransmits on parity error or ack timeout, up to a retry limit, then reports success or failure to the host.

---
 rtl/asp_tx_arq_controller_if.sv | 31 +++
 rtl/asp_tx_arq_controller.sv | 124 ++++++++++++
 2 files changed

// File: rtl/asp_tx_arq_controller_if.sv
// Host and output-stage signal bundle for the ASP stop-and-wait ARQ controller.
// master: the controller; slave: the host/output-stage side.
interface asp_tx_arq_controller_if #(
    parameter int unsigned data_size = 32,
    parameter int unsigned tag_size  = 8
);
    logic                 host_valid_in;
    logic [data_size-1:0] host_data_in;
    logic                 host_ready_out;
    logic [1:0]           opcode_out;
    logic [data_size-1:0] tx_data_out;
    logic [tag_size-1:0]  tx_tag_out;
    logic                 net_ack_in;
    logic [tag_size-1:0]  ack_tag_in;
    logic                 parity_error_in;
    logic                 send_done_out;
    logic                 send_fail_out;
    logic                 busy_out;

    modport master (
        input  host_valid_in, host_data_in, net_ack_in, ack_tag_in, parity_error_in,
        output host_ready_out, opcode_out, tx_data_out, tx_tag_out,
               send_done_out, send_fail_out, busy_out
    );

    modport slave (
        output host_valid_in, host_data_in, net_ack_in, ack_tag_in, parity_error_in,
        input  host_ready_out, opcode_out, tx_data_out, tx_tag_out,
               send_done_out, send_fail_out, busy_out
    );
endinterface

// File: rtl/asp_tx_arq_controller.sv
// Stop-and-wait ARQ sequencer for the ASP output stage: tags host words, retries on
// parity error or ack timeout. Define ASP_ARQ_STATS_EN to add retry/fail statistics ports.
module asp_tx_arq_controller #(
    parameter int unsigned data_size   = 32,
    parameter int unsigned tag_size    = 8,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned MAX_RETRIES = 3,
    localparam int unsigned TW = $clog2(TIMEOUT),
    localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    asp_tx_arq_controller_if.master bus
`ifdef ASP_ARQ_STATS_EN
    ,
    output logic [15:0]            retx_count_out,
    output logic [15:0]            fail_count_out,
    output logic [RW-1:0]          last_retries_out
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND, ST_WAIT_ACK, ST_RETRY, ST_DONE, ST_FAIL
    } state_t;

    state_t               state, state_next;
    logic [tag_size-1:0]  tag_q;
    logic [tag_size-1:0]  tx_tag_q;
    logic [data_size-1:0] tx_data_q;
    logic [RW-1:0]        retry_q;
    logic [TW-1:0]        timer_q;
    logic                 done_q;
    logic                 fail_q;

    logic ack_match;
    logic timer_expired;
    logic retry_last;

    assign ack_match     = bus.net_ack_in && (bus.ack_tag_in == tx_tag_q);
    assign timer_expired = (timer_q == TW'(TIMEOUT - 1));
    assign retry_last    = (retry_q == RW'(MAX_RETRIES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Ack outranks parity error, which outranks timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:     if (bus.host_valid_in) state_next = ST_SEND;
            ST_SEND:     state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (ack_match)                state_next = ST_DONE;
                else if (bus.parity_error_in) state_next = ST_RETRY;
                else if (timer_expired)       state_next = ST_RETRY;
            end
            ST_RETRY:    state_next = retry_last ? ST_FAIL : ST_SEND;
            ST_DONE:     state_next = ST_IDLE;
            ST_FAIL:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.host_ready_out = (state == ST_IDLE);
        bus.busy_out       = (state != ST_IDLE);
        bus.opcode_out     = 2'b00;
        if (state == ST_SEND)     bus.opcode_out = 2'b01;
        if (state == ST_WAIT_ACK) bus.opcode_out = 2'b10;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q     <= '0;
            tx_tag_q  <= '0;
            tx_data_q <= '0;
            retry_q   <= '0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            done_q <= (state == ST_DONE);
            fail_q <= (state == ST_FAIL);
            unique case (state)
                ST_IDLE: if (bus.host_valid_in) begin
                    tx_data_q <= bus.host_data_in;
                    tx_tag_q  <= tag_q;
                    retry_q   <= '0;
                end
                ST_SEND:     timer_q <= '0;
                ST_WAIT_ACK: timer_q <= timer_q + 1'b1;
                ST_RETRY:    if (!retry_last) retry_q <= retry_q + 1'b1;
                ST_DONE,
                ST_FAIL:     tag_q <= tag_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.tx_data_out   = tx_data_q;
    assign bus.tx_tag_out    = tx_tag_q;
    assign bus.send_done_out = done_q;
    assign bus.send_fail_out = fail_q;

`ifdef ASP_ARQ_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retx_count_out   <= '0;
            fail_count_out   <= '0;
            last_retries_out <= '0;
        end else begin
            if (state == ST_RETRY && !retry_last && retx_count_out != '1)
                retx_count_out <= retx_count_out + 1'b1;
            if (state == ST_FAIL && fail_count_out != '1)
                fail_count_out <= fail_count_out + 1'b1;
            if (state == ST_DONE || state == ST_FAIL)
                last_retries_out <= retry_q;
        end
    end
`endif

endmodule
